mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing the 16-bit address / 8-bit data memory between the `cpu_65c02` core and one DMA-style requester (block-transfer engine, VDC DMA). The block sits between the CPU bus (`AB`/`DO`/`WE`/`DI`/`RDY`) and the `memory` instance. It stalls the CPU through `RDY` while the DMA requester owns the bus. It bounds DMA bursts so the CPU is never starved.

## Interface
- `AW`, 16, address width
- `DW`, 8, data width
- `MAX_BURST`, 8, max consecutive DMA cycles before one forced CPU cycle (≥1)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `cpu_ab`  in  AW  CPU address
- `cpu_do`  in  DW  CPU write data
- `cpu_we`  in  1  CPU write enable
- `cpu_di`  out  DW  read data to CPU
- `cpu_rdy`  out  1  CPU ready; 0 stalls CPU, which holds `cpu_ab`/`cpu_we`/`cpu_do`
- `dma_req`  in  1  DMA request; address, data and `dma_we` held stable until granted
- `dma_addr`  in  AW  DMA address
- `dma_wdata`  in  DW  DMA write data
- `dma_we`  in  1  DMA write (1) / read (0)
- `dma_gnt`  out  1  transfer accepted this cycle
- `dma_rdata`  out  DW  DMA read data
- `dma_rvalid`  out  1  `dma_rdata` valid (one-cycle pulse)
- `mem_addr`  out  AW  to memory `addr`
- `mem_we`  out  1  to memory `we`
- `mem_din`  out  DW  to memory `dIn`
- `mem_dout`  in  DW  from memory `dOut`; read data valid the cycle after the address

## Operation
- State `owner` ∈ {OWN_CPU, OWN_DMA}; `burst_cnt` counts DMA transfers, range 0..MAX_BURST-1.
- Combinational outputs:
  - `cpu_rdy = (owner==OWN_CPU)`
  - `dma_gnt = (owner==OWN_DMA) & dma_req`
  - mux: OWN_CPU → cpu_ab/cpu_we/cpu_do; OWN_DMA → dma_addr / (dma_req & dma_we) / dma_wdata
  - No memory write may occur in OWN_DMA without `dma_req`.
- Transitions (evaluated at each edge):
  - OWN_CPU & dma_req → OWN_DMA, burst_cnt←0
  - OWN_DMA & (!dma_req | burst_cnt==MAX_BURST-1) → OWN_CPU
  - otherwise stay; burst_cnt++ on each `dma_gnt` edge.
- Fairness: after any DMA period the CPU gets ≥1 cycle. The CPU performs one access per OWN_CPU cycle, so it is guaranteed ≥1 access per MAX_BURST DMA transfers.
- Read return:
  - Register `prev_owner` and `prev_dma_rd = dma_gnt & !dma_we`.
  - `dma_rvalid = prev_dma_rd`; `dma_rdata = mem_dout`.
  - `cpu_di = mem_dout` when prev_owner==OWN_CPU. Otherwise `cpu_di` = `cpu_hold`, a register capturing `mem_dout` in every cycle where prev_owner==OWN_CPU. This keeps the CPU's last read stable while it is stalled.

## Timing
- Reset values:
  - owner=OWN_CPU, burst_cnt=0, prev_owner=OWN_CPU, prev_dma_rd=0, cpu_hold=0
  - hence cpu_rdy=1, dma_gnt=0, dma_rvalid=0
- Grant latency: req first high in cycle t → cpu_rdy=0 and dma_gnt=1 in t+1.
- DMA read issued in cycle n → dma_rvalid=1 with data in n+1. This holds even if owner returns to CPU at n+1.
- CPU read issued in cycle n → cpu_di valid in n+1.
- Handback: after the last DMA transfer, cpu_rdy=1 in the next cycle.
- Continuous dma_req, MAX_BURST=M: repeating pattern of M DMA cycles, 1 CPU cycle.
- dma_req dropping while OWN_DMA: that cycle has dma_gnt=0 and mem_we=0; owner returns to CPU next cycle.
- Reset mid-burst (reset=0 at any edge): all state as at reset, any pending rvalid is dropped. The DMA requester must reissue.
- MAX_BURST=1: strict alternation DMA/CPU.

## Structure
- Shared package `bus_pkg`:
  - `owner_t` enum (OWN_CPU, OWN_DMA)
  - `addr_t` and `data_t` typedefs sized from AW/DW defaults
- Single module. No sub-module; the burst counter and hold register are inline.

## Test plan
- Reset held low 3 cycles, dma_req=1 → cpu_rdy=1, dma_gnt=0, dma_rvalid=0 throughout reset. Grant begins the 2nd cycle after reset releases.
- CPU only: cpu_ab=16'h0200, cpu_we=1, cpu_do=8'hA5, then read 16'h0200 → mem_we=1 once; cpu_di=8'hA5 the cycle after the read address.
- DMA write 16'h1000←8'h5A, then DMA read 16'h1000 → dma_gnt each cycle, cpu_rdy=0; dma_rvalid=1 with dma_rdata=8'h5A exactly one cycle after the read grant.
- Continuous dma_req, MAX_BURST=4, 20 cycles → cpu_rdy pattern 0,0,0,0,1 repeating; no more than 4 consecutive dma_gnt.
- CPU reads 16'h0300 (=8'h77), DMA then takes 3 cycles reading other data → cpu_di stays 8'h77 while cpu_rdy=0.
- Reset asserted in the 2nd cycle of a DMA read burst → next cycle owner=OWN_CPU, dma_rvalid=0, burst_cnt=0.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the CPU/DMA memory bus.
//   ADDR_W / DATA_W : default address and data widths of the shared memory
//   owner_t         : which requester currently drives the memory port
//   addr_t / data_t : address and data word types sized from the defaults
// ---------------------------------------------------------------------------
package bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between the 65C02 core and a DMA requester.
// The CPU is stalled through cpu_rdy while the DMA side owns the port, and a
// DMA burst is cut after MAX_BURST transfers so the CPU always gets a turn.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   cpu_ab/cpu_do/cpu_we        CPU address, write data, write enable
//   cpu_di, cpu_rdy             CPU read data, CPU ready (0 = stall)
//   dma_req/dma_addr/dma_wdata  DMA request and its held transfer fields
//   dma_we                      DMA write (1) / read (0)
//   dma_gnt                     DMA transfer accepted this cycle
//   dma_rdata, dma_rvalid       DMA read data and its one-cycle valid pulse
//   mem_addr/mem_we/mem_din     memory port command
//   mem_dout                    memory read data, one cycle after address
// ---------------------------------------------------------------------------
module mem_arbiter
   import bus_pkg::*;
#(
   parameter int AW        = ADDR_W,
   parameter int DW        = DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_ab,
   input  logic [DW-1:0] cpu_do,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_di,
   output logic          cpu_rdy,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   input  logic          dma_we,
   output logic          dma_gnt,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   // A single-transfer burst still needs one counter bit to keep the
   // declarations legal; the compare value is then simply zero.
   localparam int             CW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0]  LAST = CW'(MAX_BURST - 1);

   owner_t          owner;
   owner_t          owner_next;
   owner_t          prev_owner;
   logic [CW-1:0]   burst_cnt;
   logic [CW-1:0]   burst_cnt_next;
   logic            prev_dma_rd;
   logic [DW-1:0]   cpu_hold;

   // Ownership register plus the one-cycle-delayed view of the port that
   // steers returning read data. Reset drops any read still in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         owner       <= OWN_CPU;
         burst_cnt   <= '0;
         prev_owner  <= OWN_CPU;
         prev_dma_rd <= 1'b0;
         cpu_hold    <= '0;
      end else begin
         owner       <= owner_next;
         burst_cnt   <= burst_cnt_next;
         prev_owner  <= owner;
         prev_dma_rd <= dma_gnt & ~dma_we;
         if (prev_owner == OWN_CPU) begin
            cpu_hold <= mem_dout;
         end
      end
   end

   // Next owner, burst counting and the memory port mux. A DMA write is
   // only issued while the request is actually present, so a dropped
   // request never corrupts memory on its way back to the CPU.
   always_comb begin
      owner_next     = owner;
      burst_cnt_next = burst_cnt;
      cpu_rdy        = 1'b1;
      dma_gnt        = 1'b0;
      mem_addr       = cpu_ab;
      mem_we         = cpu_we;
      mem_din        = cpu_do;
      case (owner)
         OWN_CPU: begin
            if (dma_req) begin
               owner_next     = OWN_DMA;
               burst_cnt_next = '0;
            end
         end
         OWN_DMA: begin
            cpu_rdy  = 1'b0;
            dma_gnt  = dma_req;
            mem_addr = dma_addr;
            mem_we   = dma_req & dma_we;
            mem_din  = dma_wdata;
            if (dma_req) begin
               burst_cnt_next = burst_cnt + 1'b1;
            end
            if (!dma_req || (burst_cnt == LAST)) begin
               owner_next     = OWN_CPU;
               burst_cnt_next = '0;
            end
         end
         default: begin
            owner_next = OWN_CPU;
         end
      endcase
   end

   // Read data goes straight through to whoever issued the read last cycle;
   // a stalled CPU keeps seeing its own last read rather than DMA traffic.
   assign dma_rvalid = prev_dma_rd;
   assign dma_rdata  = mem_dout;
   assign cpu_di     = (prev_owner == OWN_CPU) ? mem_dout : cpu_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives mem_arbiter with directed and random CPU/DMA traffic, backed by a
// behavioural memory. A reference model predicts every cycle's outputs into
// a queue, and a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int MAXB = 4;

   typedef struct {
      logic        rdy;
      logic        gnt;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  din;
      logic        rvalid;
      logic [7:0]  cpuDi;
   } expRec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_ab;
   logic [7:0]  cpu_do;
   logic        cpu_we;
   logic [7:0]  cpu_di;
   logic        cpu_rdy;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_we;
   logic        dma_gnt;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;

   logic [7:0]  memArr [0:65535];
   logic [7:0]  refMem [0:65535];

   expRec_t     expQ[$];
   logic [7:0]  rdQ[$];

   int          checkCount = 0;
   int          failCount  = 0;
   int          gntRun     = 0;

   // Reference model state: who owns the port, grants in this DMA period,
   // whether a DMA read result is due, and what the CPU should see on cpu_di.
   logic        mDma;
   int          mGrants;
   logic        mRvalid;
   logic [7:0]  mCpuDi;

   mem_arbiter #(.AW(16), .DW(8), .MAX_BURST(MAXB)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_ab     (cpu_ab),
      .cpu_do     (cpu_do),
      .cpu_we     (cpu_we),
      .cpu_di     (cpu_di),
      .cpu_rdy    (cpu_rdy),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_we     (dma_we),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   always #5 clk = ~clk;

   // Single-port synchronous memory: read data is the old contents of the
   // addressed byte, available the cycle after the address.
   always @(posedge clk) begin
      if (mem_we) begin
         memArr[mem_addr] <= mem_din;
      end
      mem_dout <= memArr[mem_addr];
   end

   // Compare one observed value against its expectation and keep the tally.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, queue the predicted outputs for that cycle,
   // then advance the model across the clock edge. Ownership follows the
   // rule: a waiting request takes the bus next cycle, and a DMA period lasts
   // while the request stays up and fewer than MAXB grants have been given.
   task automatic applyStimulus(input logic rstN,
                                input logic [15:0] cab, input logic [7:0] cdo, input logic cwe,
                                input logic dreq, input logic [15:0] dad, input logic [7:0] dwd,
                                input logic dwe);
      expRec_t    rec;
      logic [7:0] rd;
      reset     = rstN;
      cpu_ab    = cab;
      cpu_do    = cdo;
      cpu_we    = cwe;
      dma_req   = dreq;
      dma_addr  = dad;
      dma_wdata = dwd;
      dma_we    = dwe;
      rec.rdy    = !mDma;
      rec.gnt    = mDma && dreq;
      rec.addr   = mDma ? dad : cab;
      rec.we     = mDma ? (dreq && dwe) : cwe;
      rec.din    = mDma ? dwd : cdo;
      rec.rvalid = mRvalid;
      rec.cpuDi  = mCpuDi;
      expQ.push_back(rec);
      rd = refMem[rec.addr];
      @(posedge clk);
      if (rec.we) begin
         refMem[rec.addr] = rec.din;
      end
      if (!rstN) begin
         mDma    = 1'b0;
         mGrants = 0;
         mRvalid = 1'b0;
         mCpuDi  = rd;
      end else begin
         mRvalid = rec.gnt && !dwe;
         if (mRvalid) begin
            rdQ.push_back(rd);
         end
         if (!mDma) begin
            mCpuDi  = rd;
            mDma    = dreq;
            mGrants = 0;
         end else begin
            if (rec.gnt) begin
               mGrants++;
            end
            mDma = dreq && (mGrants < MAXB);
         end
      end
      #1;
   endtask

   // Monitor: each falling edge, pop this cycle's prediction and compare.
   // DMA read data is matched against the read-return queue whenever the
   // DUT flags it valid.
   initial begin
      expRec_t    e;
      logic [7:0] d;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cpu_rdy",    32'(cpu_rdy),    32'(e.rdy));
            checkOutput("dma_gnt",    32'(dma_gnt),    32'(e.gnt));
            checkOutput("mem_we",     32'(mem_we),     32'(e.we));
            checkOutput("mem_addr",   32'(mem_addr),   32'(e.addr));
            checkOutput("mem_din",    32'(mem_din),    32'(e.din));
            checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(e.rvalid));
            checkOutput("cpu_di",     32'(cpu_di),     32'(e.cpuDi));
            if (dma_rvalid) begin
               if (rdQ.size() > 0) begin
                  d = rdQ.pop_front();
                  checkOutput("dma_rdata", 32'(dma_rdata), 32'(d));
               end else begin
                  checkOutput("dma_rdata_unexpected", 32'(dma_rvalid), 32'd0);
               end
            end else if (e.rvalid && rdQ.size() > 0) begin
               d = rdQ.pop_front();
            end
            if (dma_gnt) begin
               gntRun++;
               checkOutput("gnt_run_bound", 32'(gntRun <= MAXB), 32'd1);
            end else begin
               gntRun = 0;
            end
         end
      end
   end

   // Stimulus: directed scenarios first, then random traffic with occasional
   // resets, then a short drain before the summary.
   initial begin
      for (int i = 0; i < 65536; i++) begin
         memArr[i] = 8'h00;
         refMem[i] = 8'h00;
      end
      reset     = 1'b0;
      cpu_ab    = 16'h0000;
      cpu_do    = 8'h00;
      cpu_we    = 1'b0;
      dma_req   = 1'b1;
      dma_addr  = 16'h0000;
      dma_wdata = 8'h00;
      dma_we    = 1'b0;
      mDma      = 1'b0;
      mGrants   = 0;
      mRvalid   = 1'b0;
      mCpuDi    = 8'h00;
      @(posedge clk);
      #1;

      $display("[TB] reset held with dma_req high");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

      $display("[TB] CPU write then read");
      applyStimulus(1'b1, 16'h0200, 8'hA5, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0201, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

      $display("[TB] DMA write then read");
      applyStimulus(1'b1, 16'h0201, 8'h00, 1'b0, 1'b1, 16'h1000, 8'h5A, 1'b1);
      applyStimulus(1'b1, 16'h0201, 8'h00, 1'b0, 1'b1, 16'h1000, 8'h5A, 1'b1);
      applyStimulus(1'b1, 16'h0201, 8'h00, 1'b0, 1'b1, 16'h1000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0201, 8'h00, 1'b0, 1'b0, 16'h1000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0201, 8'h00, 1'b0, 1'b0, 16'h1000, 8'h00, 1'b0);

      $display("[TB] continuous DMA requests");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'h0202, 8'h00, 1'b0, 1'b1, 16'(16'h2000 + i), 8'(i), 1'b1);
      applyStimulus(1'b1, 16'h0202, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0202, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

      $display("[TB] CPU read held stable while stalled");
      applyStimulus(1'b1, 16'h0300, 8'h77, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b1, 16'(16'h2001 + i), 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

      $display("[TB] reset during DMA read burst");
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b1, 16'h1000, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b1, 16'h1000, 8'h00, 1'b0);
      applyStimulus(1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 16'h2002, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h2002, 8'h00, 1'b0);
      applyStimulus(1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h2002, 8'h00, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0),
                       16'(16'h0400 + $urandom_range(0, 15)), 8'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0),
                       16'(16'h0400 + $urandom_range(0, 15)), 8'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0400, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

      repeat (2) @(posedge clk);
      checkOutput("queues_drained", 32'(expQ.size() + rdQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
